// File: rtl/dct_deskew_collect.sv
// ============================================================================
// dct_deskew_collect
//
// Final stage of the bit-serial approximate 1D DCT adder pipeline. The adder
// produces its sum bits in a diagonal skew: bit 0 of a word arrives first.
// Each higher bit arrives one cycle later, and the top two bits arrive
// together. This block does four things:
//   - realigns those bits into parallel words;
//   - packs N consecutive words into one coefficient vector;
//   - presents the vector on a valid/ready port;
//   - keeps two vector banks, so collection continues while the consumer
//     stalls.
//
// Optional feature macro: DCT_DESKEW_ROUND_EN
//   defined   : coefficients are OW = W-1 bits, each (word + 1) >>> 1 with
//               saturation at the largest positive value.
//   undefined : coefficients are OW = W bits, stored bit-exact.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   s_in       in   W      skewed sum bits from the bit-serial adder
//   s_valid    in   1      high in the cycle bit 0 of a new word is on s_in[0]
//   out_ready  in   1      consumer accepts the presented vector
//   out_valid  out  1      coef_vec holds a complete vector
//   coef_vec   out  N*OW   coefficient k at [k*OW +: OW], k=0 received first
//   overflow   out  1      sticky: a word arrived with both banks full
//   fill_cnt   out  log2N  words stored so far in the bank being filled
// ============================================================================
module dct_deskew_collect #(
    parameter int W = 9,
    parameter int N = 8
`ifdef DCT_DESKEW_ROUND_EN
    , localparam int OW = W - 1
`else
    , localparam int OW = W
`endif
    , localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    s_in,
    input  logic            s_valid,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [N*OW-1:0] coef_vec,
    output logic            overflow,
    output logic [CW-1:0]   fill_cnt
);

    logic [W-1:0]  aligned;
    logic [W-3:0]  vld_dly;
    logic          aligned_valid;
    logic [OW-1:0] store_word;

    logic [OW-1:0] bank [2][N];
    logic [1:0]    full;
    logic          wr_ptr;
    logic          rd_ptr;

    logic          take;
    logic          blocked;
    logic          do_write;
    logic          last_slot;

    // Triangular deskew. Bit i is held back W-2-i cycles, so every bit lands
    // in the cycle when the top two bits arrive straight from s_in.
    for (genvar i = 0; i < W - 2; i++) begin : g_skew
        localparam int D = W - 2 - i;
        logic [D-1:0] chain;
        if (D == 1) begin : g_one
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) chain <= '0;
                else        chain <= s_in[i];
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) chain <= '0;
                else        chain <= {chain[D-2:0], s_in[i]};
            end
        end
        assign aligned[i] = chain[D-1];
    end

    assign aligned[W-1:W-2] = s_in[W-1:W-2];

    // The valid bit follows the slowest bit of its word. Clearing this chain
    // on reset discards any word that is only partly received.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_dly <= '0;
        else        vld_dly <= {vld_dly[W-4:0], s_valid};
    end

    assign aligned_valid = vld_dly[W-3];

`ifdef DCT_DESKEW_ROUND_EN
    // (w + 1) >>> 1 equals floor(w / 2) + w[0]. This form needs no extra
    // guard bit. Only the most positive input can exceed the OW-bit range.
    localparam logic [OW-1:0] MAX_POS = {1'b0, {(OW-1){1'b1}}};
    logic [W-1:0] half;

    always_comb begin
        half = {aligned[W-1], aligned[W-1:1]} + W'(aligned[0]);
        if (!half[W-1] && half[W-2]) store_word = MAX_POS;
        else                         store_word = half[OW-1:0];
    end
`else
    assign store_word = aligned;
`endif

    // Freeing a bank and filling it can happen in the same cycle. A word
    // that aligns while both banks are full is still accepted if the
    // consumer frees the bank being read (wr_ptr == rd_ptr) in that cycle.
    assign take      = full[rd_ptr] & out_ready;
    assign blocked   = full[wr_ptr] & ~(take & (rd_ptr == wr_ptr));
    assign do_write  = aligned_valid & ~blocked;
    assign last_slot = (fill_cnt == CW'(N - 1));

    // Bank bookkeeping: full flags, write/read pointers, slot counter and
    // the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fill_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (take) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
            if (do_write) begin
                if (last_slot) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                    fill_cnt     <= '0;
                end else begin
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
            if (aligned_valid && blocked) overflow <= 1'b1;
        end
    end

    // Coefficient storage. Writes only target the bank being filled. A
    // presented bank therefore stays frozen until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < N; k++)
                    bank[b][k] <= '0;
        end else if (do_write) begin
            bank[wr_ptr][fill_cnt] <= store_word;
        end
    end

    // The output shows the bank under the read pointer. It comes only from
    // registers, so there is no path from s_in to coef_vec.
    always_comb begin
        coef_vec = '0;
        for (int k = 0; k < N; k++)
            coef_vec[k*OW +: OW] = bank[rd_ptr][k];
    end

    assign out_valid = full[rd_ptr];

endmodule

// File: tb/tb_dct_deskew_collect.sv
// ============================================================================
// tb_dct_deskew_collect
//
// Directed bench for dct_deskew_collect. Words are skewed the way the
// upstream bit-serial adder skews them. The bench covers reset, alignment
// and latency, back-pressure with overflow, a handshake that frees a bank in
// the same cycle a word aligns, pointer wrap-around and the rounding option.
// ============================================================================
module tb_dct_deskew_collect;

    localparam int W = 9;
    localparam int N = 8;
`ifdef DCT_DESKEW_ROUND_EN
    localparam int OW = W - 1;
`else
    localparam int OW = W;
`endif
    localparam int VW = N * OW;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  s_in;
    logic          s_valid;
    logic          out_ready;
    logic          out_valid;
    logic [VW-1:0] coef_vec;
    logic          overflow;
    logic [2:0]    fill_cnt;

    int checks = 0;
    int errors = 0;
    int nvec;

    logic [W-1:0] hist_w [0:W-2];
    logic [W-1:0] words  [0:63];
    logic [VW-1:0] round_vec;

    dct_deskew_collect #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .coef_vec  (coef_vec),
        .overflow  (overflow),
        .fill_cnt  (fill_cnt)
    );

    // 10-time-unit clock period
    always #5 clk = ~clk;

    // Watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it when it does not match
    task checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of skewed input, then advances past the clock edge.
    // hist_w[k] is the word started k cycles ago. Bit i comes from the word
    // started i cycles ago, and the top bit shares the delay of bit W-2.
    task applyStimulus(input logic v, input logic [W-1:0] w);
        for (int k = W - 2; k > 0; k--) hist_w[k] = hist_w[k-1];
        hist_w[0] = v ? w : '0;
        s_valid = v;
        for (int i = 0; i <= W - 2; i++) s_in[i] = hist_w[i][i];
        s_in[W-1] = hist_w[W-2][W-1];
        @(posedge clk);
        #1;
    endtask

    task idleCycles(input int n);
        for (int j = 0; j < n; j++) applyStimulus(1'b0, '0);
    endtask

    task sendWords(input int base, input int count);
        for (int j = 0; j < count; j++) applyStimulus(1'b1, words[base+j]);
    endtask

    task clearHist();
        for (int k = 0; k <= W - 2; k++) hist_w[k] = '0;
        s_in    = '0;
        s_valid = 1'b0;
    endtask

    task doReset();
        reset = 1'b0;
        clearHist();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task consumeOne();
        out_ready = 1'b1;
        idleCycles(1);
        out_ready = 1'b0;
    endtask

    // Expected stored value of one word
    function automatic logic [OW-1:0] expWord(input logic [W-1:0] w);
`ifdef DCT_DESKEW_ROUND_EN
        int s;
        int r;
        s = w[W-1] ? int'(w) - (1 << W) : int'(w);
        r = (s + 1) >>> 1;
        if (r > (1 << (W - 2)) - 1) r = (1 << (W - 2)) - 1;
        return OW'(r);
`else
        return w;
`endif
    endfunction

    function automatic logic [VW-1:0] packVec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*OW +: OW] = expWord(words[base+k]);
        return v;
    endfunction

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        clearHist();

        // ---- reset state --------------------------------------------------
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_coef_vec", coef_vec, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_fill_cnt", fill_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // ---- skew alignment and latency -----------------------------------
        words[0] = 9'h0A5; words[1] = 9'h15A; words[2] = 9'h1FF; words[3] = 9'h000;
        words[4] = 9'h100; words[5] = 9'h0FF; words[6] = 9'h001; words[7] = 9'h180;
        sendWords(0, 8);
        idleCycles(6);
        checkOutput("latency_early", out_valid, 0);
        idleCycles(1);
        checkOutput("latency_valid", out_valid, 1);
        checkOutput("skew_vec", coef_vec, packVec(0));
        checkOutput("skew_fill_cnt", fill_cnt, 0);
        consumeOne();
        checkOutput("skew_drained", out_valid, 0);

        // ---- reset mid-stream ---------------------------------------------
        words[8] = 9'h011; words[9] = 9'h022; words[10] = 9'h033;
        sendWords(8, 3);
        idleCycles(7);
        checkOutput("partial_fill_cnt", fill_cnt, 3);
        applyStimulus(1'b1, 9'h044);
        idleCycles(2);
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_fill_cnt", fill_cnt, 0);
        checkOutput("midrst_overflow", overflow, 0);
        clearHist();
        @(posedge clk);
        #1 reset = 1'b1;
        idleCycles(10);
        checkOutput("inflight_lost", fill_cnt, 0);
        checkOutput("inflight_no_ovf", overflow, 0);
        for (int k = 0; k < N; k++) words[16+k] = W'(9'h040 + k);
        sendWords(16, 8);
        idleCycles(7);
        checkOutput("postrst_valid", out_valid, 1);
        checkOutput("postrst_vec", coef_vec, packVec(16));
        consumeOne();

        // ---- back-pressure and overflow -----------------------------------
        for (int k = 0; k < 16; k++) words[24+k] = W'(k * 37 + 5);
        sendWords(24, 16);
        idleCycles(7);
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_vec", coef_vec, packVec(24));
        checkOutput("bp_fill_cnt", fill_cnt, 0);
        checkOutput("bp_no_ovf", overflow, 0);
        idleCycles(3);
        checkOutput("bp_stable", coef_vec, packVec(24));
        applyStimulus(1'b1, 9'h0AA);
        idleCycles(7);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_fill_cnt", fill_cnt, 0);
        checkOutput("ovf_vec_kept", coef_vec, packVec(24));
        out_ready = 1'b1;
        idleCycles(1);
        checkOutput("bp_second_valid", out_valid, 1);
        checkOutput("bp_second_vec", coef_vec, packVec(32));
        idleCycles(1);
        out_ready = 1'b0;
        checkOutput("bp_empty", out_valid, 0);
        checkOutput("ovf_sticky", overflow, 1);
        doReset();
        checkOutput("ovf_cleared", overflow, 0);

        // ---- handshake frees a bank as a word aligns ----------------------
        for (int k = 0; k < 24; k++) words[40+k] = W'(k * 53 + 100);
        sendWords(40, 17);
        idleCycles(6);
        checkOutput("sim_both_full", out_valid, 1);
        out_ready = 1'b1;
        applyStimulus(1'b0, '0);
        out_ready = 1'b0;
        checkOutput("sim_no_ovf", overflow, 0);
        checkOutput("sim_fill_cnt", fill_cnt, 1);
        checkOutput("sim_next_valid", out_valid, 1);
        checkOutput("sim_next_vec", coef_vec, packVec(48));
        consumeOne();
        checkOutput("sim_drained", out_valid, 0);
        sendWords(57, 7);
        idleCycles(7);
        checkOutput("sim_slot0_valid", out_valid, 1);
        checkOutput("sim_slot0_vec", coef_vec, packVec(56));
        consumeOne();

        // ---- continuous streaming, pointers wrap --------------------------
        for (int k = 0; k < 40; k++) words[k] = W'(k * 29 + 7);
        nvec = 0;
        out_ready = 1'b1;
        for (int j = 0; j < 50; j++) begin
            if (j < 40) applyStimulus(1'b1, words[j]);
            else        applyStimulus(1'b0, '0);
            if (out_valid) begin
                if (nvec < 5)
                    checkOutput($sformatf("wrap_vec%0d", nvec), coef_vec, packVec(nvec * N));
                nvec++;
            end
        end
        out_ready = 1'b0;
        checkOutput("wrap_count", nvec, 5);
        checkOutput("wrap_no_ovf", overflow, 0);
        checkOutput("wrap_fill_cnt", fill_cnt, 0);
        checkOutput("wrap_idle", out_valid, 0);

        // ---- rounding / bit-exact storage ---------------------------------
        words[0] = 9'h003; words[1] = 9'h1FD; words[2] = 9'h0FF; words[3] = 9'h100;
        words[4] = 9'h000; words[5] = 9'h001; words[6] = 9'h1FF; words[7] = 9'h002;
`ifdef DCT_DESKEW_ROUND_EN
        round_vec = {8'h01, 8'h00, 8'h01, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h02};
`else
        round_vec = {9'h002, 9'h1FF, 9'h001, 9'h000, 9'h100, 9'h0FF, 9'h1FD, 9'h003};
`endif
        sendWords(0, 8);
        idleCycles(7);
        checkOutput("round_valid", out_valid, 1);
        checkOutput("round_vec", coef_vec, round_vec);
        consumeOne();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
